// File: rtl/crc_stream.sv
// Packet CRC engine: folds keep-qualified bytes of a valid/ready stream into a generic CRC.
// Defining CRC_STREAM_CHECK_EN adds exp_crc_i / crc_ok_o result checking.
module crc_stream #(
    parameter logic [63:0] POLY       = 64'h1021,
    parameter int          CRC_SIZE   = 16,
    parameter int          DATA_WIDTH = 32,
    parameter logic [63:0] INIT       = 64'hFFFF,
    parameter int          REF_IN     = 1,
    parameter int          REF_OUT    = 1,
    parameter logic [63:0] XOR_OUT    = 64'h0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    soft_reset_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic [DATA_WIDTH/8-1:0] s_keep_i,
    input  logic                    s_last_i,
    output logic                    crc_valid_o,
    input  logic                    crc_ready_i,
    output logic [CRC_SIZE-1:0]     crc_o
`ifdef CRC_STREAM_CHECK_EN
    ,
    input  logic [CRC_SIZE-1:0]     exp_crc_i,
    output logic                    crc_ok_o
`endif
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [CRC_SIZE-1:0] POLY_C = POLY[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] INIT_C = INIT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] XOR_C  = XOR_OUT[CRC_SIZE-1:0];

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CRC_SIZE-1:0] crcReg_q, crcReg_d;
    logic [CRC_SIZE-1:0] crcOut_q, crcOut_d;
    logic                crcValid_q, crcValid_d;
    logic                sReady_q, sReady_d;

    logic [CRC_SIZE-1:0] foldedCrc;
    logic [CRC_SIZE-1:0] finalCrc;
    logic                beatTaken;
    logic                lastTaken;
    logic [NB-1:0]       keepPlusOne;

    // Bytes go in ascending lane order, each as 8 MSB-first bit steps after optional reflection.
    function automatic logic [CRC_SIZE-1:0] foldBeat(input logic [CRC_SIZE-1:0] crcIn,
                                                     input logic [DATA_WIDTH-1:0] data,
                                                     input logic [NB-1:0] keep);
        logic [CRC_SIZE-1:0] c;
        logic [7:0]          byteBits;
        logic                fb;
        c = crcIn;
        for (int b = 0; b < NB; b++) begin
            byteBits = data[8*b +: 8];
            if (keep[b]) begin
                for (int k = 0; k < 8; k++) begin
                    fb = c[CRC_SIZE-1] ^ ((REF_IN != 0) ? byteBits[k] : byteBits[7-k]);
                    c  = c << 1;
                    if (fb) c = c ^ POLY_C;
                end
            end
        end
        return c;
    endfunction

    function automatic logic [CRC_SIZE-1:0] reflectCrc(input logic [CRC_SIZE-1:0] c);
        logic [CRC_SIZE-1:0] r;
        for (int i = 0; i < CRC_SIZE; i++) r[i] = c[CRC_SIZE-1-i];
        return r;
    endfunction

    assign foldedCrc   = foldBeat(crcReg_q, s_data_i, s_keep_i);
    assign finalCrc    = ((REF_OUT != 0) ? reflectCrc(foldedCrc) : foldedCrc) ^ XOR_C;
    assign beatTaken   = !soft_reset_i && state_q == ACCUM && s_valid_i && sReady_q;
    assign lastTaken   = beatTaken && s_last_i;
    assign keepPlusOne = s_keep_i + NB'(1);

    always_comb begin
        state_d    = state_q;
        crcReg_d   = crcReg_q;
        crcOut_d   = crcOut_q;
        crcValid_d = crcValid_q;
        sReady_d   = sReady_q;
        if (soft_reset_i) begin
            state_d    = ACCUM;
            crcReg_d   = INIT_C;
            crcValid_d = 1'b0;
            sReady_d   = 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    sReady_d = 1'b1;
                    if (beatTaken) crcReg_d = foldedCrc;
                    if (lastTaken) begin
                        crcOut_d   = finalCrc;
                        crcValid_d = 1'b1;
                        sReady_d   = 1'b0;
                        crcReg_d   = INIT_C;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (crcValid_q && crc_ready_i) begin
                        crcValid_d = 1'b0;
                        sReady_d   = 1'b1;
                        state_d    = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACCUM;
            crcReg_q   <= INIT_C;
            crcOut_q   <= '0;
            crcValid_q <= 1'b0;
            sReady_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            crcReg_q   <= crcReg_d;
            crcOut_q   <= crcOut_d;
            crcValid_q <= crcValid_d;
            sReady_q   <= sReady_d;
        end
    end

    assign s_ready_o   = sReady_q;
    assign crc_valid_o = crcValid_q;
    assign crc_o       = crcOut_q;

`ifdef CRC_STREAM_CHECK_EN
    logic crcOk_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) crcOk_q <= 1'b0;
        else if (lastTaken) crcOk_q <= (finalCrc == exp_crc_i);
    end

    assign crc_ok_o = crcOk_q;
`endif

    // Middle beats must be full; a last beat may only trim bytes from the top lane down.
    always @(posedge clk_i) begin
        if (!rst_i && s_valid_i && sReady_q)
            assert (s_last_i ? ((s_keep_i & keepPlusOne) == '0) : (&s_keep_i));
    end

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: byte-queue reference model, per-cycle compare, directed and random packets.
module tb_crc_stream;

    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef logic [7:0] byteQ_t[$];

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_i        = 1'b1;
    logic          soft_reset_i = 1'b0;
    logic          s_valid_i    = 1'b0;
    logic [DW-1:0] s_data_i     = '0;
    logic [NB-1:0] s_keep_i     = '0;
    logic          s_last_i     = 1'b0;
    logic          crc_ready_i  = 1'b0;
    wire           s_ready_o;
    wire           crc_valid_o;
    wire  [15:0]   crc_o;

    logic       bValid = 1'b0;
    logic       bLast  = 1'b0;
    logic [7:0] bData  = '0;
    logic       bKeep  = 1'b1;
    logic       bReady = 1'b1;
    wire        b16Ready, b16Valid, b32Ready, b32Valid;
    wire [15:0] b16Crc;
    wire [31:0] b32Crc;

`ifdef CRC_STREAM_CHECK_EN
    logic [15:0] exp_crc_i = 16'h6F91;
    wire         crc_ok_o;
    logic [15:0] b16Exp = '0;
    logic [31:0] b32Exp = '0;
    wire         b16Ok, b32Ok;
`endif

    crc_stream u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .soft_reset_i(soft_reset_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_keep_i(s_keep_i), .s_last_i(s_last_i),
        .crc_valid_o(crc_valid_o), .crc_ready_i(crc_ready_i), .crc_o(crc_o)
`ifdef CRC_STREAM_CHECK_EN
        , .exp_crc_i(exp_crc_i), .crc_ok_o(crc_ok_o)
`endif
    );

    crc_stream #(.DATA_WIDTH(8)) u_b16 (
        .clk_i(clk_i), .rst_i(rst_i), .soft_reset_i(1'b0),
        .s_valid_i(bValid), .s_ready_o(b16Ready), .s_data_i(bData),
        .s_keep_i(bKeep), .s_last_i(bLast),
        .crc_valid_o(b16Valid), .crc_ready_i(bReady), .crc_o(b16Crc)
`ifdef CRC_STREAM_CHECK_EN
        , .exp_crc_i(b16Exp), .crc_ok_o(b16Ok)
`endif
    );

    crc_stream #(.POLY(64'h04C11DB7), .CRC_SIZE(32), .DATA_WIDTH(8),
                 .INIT(64'hFFFFFFFF), .XOR_OUT(64'hFFFFFFFF)) u_b32 (
        .clk_i(clk_i), .rst_i(rst_i), .soft_reset_i(1'b0),
        .s_valid_i(bValid), .s_ready_o(b32Ready), .s_data_i(bData),
        .s_keep_i(bKeep), .s_last_i(bLast),
        .crc_valid_o(b32Valid), .crc_ready_i(bReady), .crc_o(b32Crc)
`ifdef CRC_STREAM_CHECK_EN
        , .exp_crc_i(b32Exp), .crc_ok_o(b32Ok)
`endif
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference CRC in LSB-first reflected form over a plain byte list.
    function automatic logic [63:0] refCrc(input byteQ_t q, input logic [63:0] rpoly,
                                           input logic [63:0] init, input logic [63:0] xo);
        logic [63:0] c;
        c = init;
        foreach (q[i]) begin
            c = c ^ 64'(q[i]);
            repeat (8) c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
        end
        return c ^ xo;
    endfunction

    byteQ_t      pktBytes;
    logic        mReady = 1'b0;
    logic        mValid = 1'b0;
    logic [15:0] mOut   = '0;
    logic        mOk    = 1'b0;

    // Transaction-level model of framing and handshakes for the main DUT.
    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            mReady = 1'b0; mValid = 1'b0; mOut = '0; mOk = 1'b0;
            pktBytes.delete();
        end else if (soft_reset_i) begin
            mReady = 1'b1; mValid = 1'b0;
            pktBytes.delete();
        end else if (mValid) begin
            if (crc_ready_i) begin
                mValid = 1'b0; mReady = 1'b1;
            end
        end else begin
            if (s_valid_i && mReady) begin
                for (int b = 0; b < NB; b++)
                    if (s_keep_i[b]) pktBytes.push_back(s_data_i[8*b +: 8]);
                if (s_last_i) begin
                    mOut = 16'(refCrc(pktBytes, 64'h8408, 64'hFFFF, 64'h0));
`ifdef CRC_STREAM_CHECK_EN
                    mOk = (mOut == exp_crc_i);
`endif
                    mValid = 1'b1;
                    pktBytes.delete();
                end
            end
            mReady = !mValid;
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (!rst_i) begin
            checkOutput("cmp_s_ready", s_ready_o, mReady);
            checkOutput("cmp_crc_valid", crc_valid_o, mValid);
            checkOutput("cmp_crc", crc_o, mOut);
`ifdef CRC_STREAM_CHECK_EN
            checkOutput("cmp_crc_ok", crc_ok_o, mOk);
`endif
        end
    end

    bit   randReady  = 1'b0;
    logic readyForce = 1'b1;

    initial forever begin
        @(negedge clk_i);
        crc_ready_i = randReady ? 1'($urandom_range(0, 1)) : readyForce;
    end

    // Offer one beat at a negedge; return at the negedge after it is taken.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic [NB-1:0] keep, input logic last);
        s_data_i = data; s_keep_i = keep; s_last_i = last; s_valid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (s_ready_o) begin
                @(negedge clk_i);
                s_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        checkOutput("beat_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic sendDigits();
        applyStimulus(32'h34333231, 4'hF, 1'b0);
        applyStimulus(32'h38373635, 4'hF, 1'b0);
        applyStimulus(32'h00000039, 4'h1, 1'b1);
    endtask

    task automatic waitResult(input string name, input logic [15:0] expected);
        for (int n = 0; n < 100; n++) begin
            if (crc_valid_o) begin
                checkOutput(name, crc_o, expected);
                return;
            end
            @(negedge clk_i);
        end
        checkOutput({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic pulseAsyncReset(input string name);
        #1 rst_i = 1'b1;
        #1;
        checkOutput({name, "_ready"}, s_ready_o, 1'b0);
        checkOutput({name, "_valid"}, crc_valid_o, 1'b0);
        checkOutput({name, "_crc"}, crc_o, 16'h0);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        byteQ_t digits;
        int     nBeats;
        int     nKeep;
        for (int i = 0; i < 9; i++) digits.push_back(8'(8'h31 + i));
        checkOutput("model_pin_crc16", refCrc(digits, 64'h8408, 64'hFFFF, 64'h0), 64'h6F91);
        checkOutput("model_pin_crc32", refCrc(digits, 64'hEDB88320, 64'hFFFFFFFF, 64'hFFFFFFFF), 64'hCBF43926);

        repeat (2) @(negedge clk_i);
        checkOutput("reset_ready", s_ready_o, 1'b0);
        checkOutput("reset_valid", crc_valid_o, 1'b0);
        checkOutput("reset_crc", crc_o, 16'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("ready_after_reset", s_ready_o, 1'b1);

        sendDigits();
        checkOutput("t1_valid_latency", crc_valid_o, 1'b1);
        checkOutput("t1_crc", crc_o, 16'h6F91);
`ifdef CRC_STREAM_CHECK_EN
        checkOutput("t6_ok_match", crc_ok_o, 1'b1);
`endif
        @(negedge clk_i);
        checkOutput("t1_consumed_valid", crc_valid_o, 1'b0);
        checkOutput("t1_ready_again", s_ready_o, 1'b1);

        readyForce = 1'b0;
        @(negedge clk_i);
        sendDigits();
        s_data_i = 32'h34333231; s_keep_i = 4'hF; s_last_i = 1'b0; s_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            checkOutput("t3_hold_crc", crc_o, 16'h6F91);
            checkOutput("t3_hold_valid", crc_valid_o, 1'b1);
            checkOutput("t3_hold_ready", s_ready_o, 1'b0);
        end
        readyForce = 1'b1;
        applyStimulus(32'h34333231, 4'hF, 1'b0);
        applyStimulus(32'h38373635, 4'hF, 1'b0);
        applyStimulus(32'h00000039, 4'h1, 1'b1);
        waitResult("t3_after_hold", 16'h6F91);
        sendDigits();
        waitResult("t3_b2b_first", 16'h6F91);
        sendDigits();
        waitResult("t3_b2b_second", 16'h6F91);

        applyStimulus(32'h34333231, 4'hF, 1'b0);
        s_data_i = 32'h38373635; s_valid_i = 1'b1; soft_reset_i = 1'b1;
        @(negedge clk_i);
        soft_reset_i = 1'b0; s_valid_i = 1'b0;
        sendDigits();
        waitResult("t4_soft_reset", 16'h6F91);
        applyStimulus(32'h0, 4'h0, 1'b1);
        waitResult("t4_keep_zero", 16'hFFFF);

        readyForce = 1'b0;
        @(negedge clk_i);
        sendDigits();
        pulseAsyncReset("t5_rst_hold");
        readyForce = 1'b1;
        applyStimulus(32'h34333231, 4'hF, 1'b0);
        applyStimulus(32'h38373635, 4'hF, 1'b0);
        pulseAsyncReset("t5_rst_mid");
        sendDigits();
        waitResult("t5_after_rst", 16'h6F91);

`ifdef CRC_STREAM_CHECK_EN
        exp_crc_i = 16'h6F90;
        sendDigits();
        checkOutput("t6_ok_mismatch", crc_ok_o, 1'b0);
        exp_crc_i = 16'h6F91;
`endif

        randReady = 1'b1;
        for (int p = 0; p < 300; p++) begin
            nBeats = $urandom_range(1, 4);
            for (int b = 0; b < nBeats; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                if ($urandom_range(0, 31) == 0) begin
                    s_valid_i = 1'($urandom_range(0, 1));
                    s_data_i = $urandom; s_keep_i = 4'hF; s_last_i = 1'b0;
                    soft_reset_i = 1'b1;
                    @(negedge clk_i);
                    soft_reset_i = 1'b0; s_valid_i = 1'b0;
                end
                if (b == nBeats - 1) begin
                    nKeep = $urandom_range(0, NB);
                    applyStimulus($urandom, NB'((1 << nKeep) - 1), 1'b1);
                end else begin
                    applyStimulus($urandom, 4'hF, 1'b0);
                end
            end
        end
        randReady = 1'b0;
        repeat (5) @(negedge clk_i);

        for (int i = 0; i < 9; i++) begin
            bData = 8'(8'h31 + i); bLast = (i == 8); bValid = 1'b1;
            for (int n = 0; n < 50 && !b16Ready; n++) @(negedge clk_i);
            checkOutput("t2_byte_ready", b16Ready & b32Ready, 1'b1);
            @(negedge clk_i);
            bValid = 1'b0;
        end
        checkOutput("t2_valid", b16Valid & b32Valid, 1'b1);
        checkOutput("t2_crc16_dw8", b16Crc, 16'h6F91);
        checkOutput("t2_crc32_dw8", b32Crc, 32'hCBF43926);
        checkOutput("t2_crc32_model", b32Crc, refCrc(digits, 64'hEDB88320, 64'hFFFFFFFF, 64'hFFFFFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
